// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer with CDB capture, commit port and flush.
module reorder_buffer #(
  parameter int ROB_SIZE = 15,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_decode_valid,
  input  logic [4:0]        in_decode_rd,
  input  logic              in_decode_is_store,
  output logic [TAG_W-1:0]  out_rob_free_tag,
  output logic              out_rob_full,
  input  logic              in_cdb_valid,
  input  logic [TAG_W-1:0]  in_cdb_reorder,
  input  logic [DATA_W-1:0] in_cdb_value,
  input  logic              in_cdb_misbranch,
  input  logic [DATA_W-1:0] in_cdb_target,
  input  logic [TAG_W-1:0]  in_query1_reorder,
  input  logic [TAG_W-1:0]  in_query2_reorder,
  output logic              out_query1_ready,
  output logic              out_query2_ready,
  output logic [DATA_W-1:0] out_query1_value,
  output logic [DATA_W-1:0] out_query2_value,
  output logic [4:0]        out_rob_index,
  output logic [DATA_W-1:0] out_rob_value,
  output logic [TAG_W-1:0]  out_rob_reorder,
  output logic              out_store_commit,
  output logic              out_misbranch,
  output logic [DATA_W-1:0] out_misbranch_pc
);
  localparam int DEPTH = 2 ** TAG_W;
  localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ROB_SIZE);

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;

  logic              busy_q     [DEPTH];
  logic              ready_q    [DEPTH];
  logic              is_store_q [DEPTH];
  logic              misb_q     [DEPTH];
  logic [4:0]        rd_q       [DEPTH];
  logic [DATA_W-1:0] value_q    [DEPTH];
  logic [DATA_W-1:0] target_q   [DEPTH];

  logic [TAG_W-1:0]  head_q, tail_q, count_q;
  logic [4:0]        index_q;
  logic [DATA_W-1:0] commit_value_q, misbranch_pc_q, flush_pc_q;
  logic [TAG_W-1:0]  reorder_q;
  logic              store_commit_q, misbranch_q;

  logic full, do_dispatch, do_commit, cdb_hit;

  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (t == LAST_TAG) ? FIRST_TAG : t + FIRST_TAG;
  endfunction

  // Result lookup with same-cycle CDB bypass; packed as {ready, value}.
  function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
    logic bypass, stored;
    bypass = (tag != '0) && in_cdb_valid && (in_cdb_reorder == tag);
    stored = (tag != '0) && busy_q[tag] && ready_q[tag];
    if (bypass)      return {1'b1, in_cdb_value};
    else if (stored) return {1'b1, value_q[tag]};
    else             return '0;
  endfunction

  assign {out_query1_ready, out_query1_value} = lookup(in_query1_reorder);
  assign {out_query2_ready, out_query2_value} = lookup(in_query2_reorder);

  always_comb begin
    state_d     = state_q;
    full        = (count_q == LAST_TAG) || (state_q == FLUSH);
    do_dispatch = 1'b0;
    do_commit   = 1'b0;
    cdb_hit     = 1'b0;
    case (state_q)
      RUN: begin
        do_dispatch = in_decode_valid && !full;
        do_commit   = busy_q[head_q] && ready_q[head_q];
        cdb_hit     = in_cdb_valid && (in_cdb_reorder != '0) && busy_q[in_cdb_reorder];
        if (do_commit && misb_q[head_q]) state_d = FLUSH;
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state_q <= RUN;
    else if (rdy) state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0; ready_q[i] <= 1'b0; is_store_q[i] <= 1'b0; misb_q[i] <= 1'b0;
        rd_q[i] <= '0; value_q[i] <= '0; target_q[i] <= '0;
      end
      head_q <= FIRST_TAG; tail_q <= FIRST_TAG; count_q <= '0;
      index_q <= '0; commit_value_q <= '0; reorder_q <= '0;
      store_commit_q <= 1'b0; misbranch_q <= 1'b0;
      misbranch_pc_q <= '0; flush_pc_q <= '0;
    end else if (rdy) begin
      index_q <= '0; commit_value_q <= '0; reorder_q <= '0;
      store_commit_q <= 1'b0; misbranch_q <= 1'b0;
      if (state_q == FLUSH) begin
        for (int i = 0; i < DEPTH; i++) begin
          busy_q[i] <= 1'b0; ready_q[i] <= 1'b0;
        end
        head_q <= FIRST_TAG; tail_q <= FIRST_TAG; count_q <= '0;
        misbranch_q <= 1'b1; misbranch_pc_q <= flush_pc_q;
      end else begin
        if (cdb_hit) begin
          ready_q[in_cdb_reorder]  <= 1'b1;
          value_q[in_cdb_reorder]  <= in_cdb_value;
          misb_q[in_cdb_reorder]   <= in_cdb_misbranch;
          target_q[in_cdb_reorder] <= in_cdb_target;
        end
        if (do_dispatch) begin
          busy_q[tail_q] <= 1'b1; ready_q[tail_q] <= 1'b0; misb_q[tail_q] <= 1'b0;
          rd_q[tail_q] <= in_decode_rd; is_store_q[tail_q] <= in_decode_is_store;
          tail_q <= next_tag(tail_q);
        end
        if (do_commit) begin
          busy_q[head_q] <= 1'b0;
          index_q        <= is_store_q[head_q] ? 5'd0 : rd_q[head_q];
          commit_value_q <= value_q[head_q];
          reorder_q      <= head_q;
          store_commit_q <= is_store_q[head_q];
          if (misb_q[head_q]) flush_pc_q <= target_q[head_q];
          head_q <= next_tag(head_q);
        end
        if (do_dispatch && !do_commit)      count_q <= count_q + FIRST_TAG;
        else if (!do_dispatch && do_commit) count_q <= count_q - FIRST_TAG;
      end
    end
  end

  assign out_rob_free_tag = tail_q;
  assign out_rob_full     = full;
  assign out_rob_index    = index_q;
  assign out_rob_value    = commit_value_q;
  assign out_rob_reorder  = reorder_q;
  assign out_store_commit = store_commit_q;
  assign out_misbranch    = misbranch_q;
  assign out_misbranch_pc = misbranch_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic        in_decode_valid = 1'b0, in_decode_is_store = 1'b0;
  logic [4:0]  in_decode_rd = '0;
  logic [3:0]  out_rob_free_tag;
  logic        out_rob_full;
  logic        in_cdb_valid = 1'b0, in_cdb_misbranch = 1'b0;
  logic [3:0]  in_cdb_reorder = '0;
  logic [31:0] in_cdb_value = '0, in_cdb_target = '0;
  logic [3:0]  in_query1_reorder = '0, in_query2_reorder = '0;
  logic        out_query1_ready, out_query2_ready;
  logic [31:0] out_query1_value, out_query2_value;
  logic [4:0]  out_rob_index;
  logic [31:0] out_rob_value;
  logic [3:0]  out_rob_reorder;
  logic        out_store_commit, out_misbranch;
  logic [31:0] out_misbranch_pc;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_decode_valid(in_decode_valid), .in_decode_rd(in_decode_rd),
    .in_decode_is_store(in_decode_is_store),
    .out_rob_free_tag(out_rob_free_tag), .out_rob_full(out_rob_full),
    .in_cdb_valid(in_cdb_valid), .in_cdb_reorder(in_cdb_reorder),
    .in_cdb_value(in_cdb_value), .in_cdb_misbranch(in_cdb_misbranch),
    .in_cdb_target(in_cdb_target),
    .in_query1_reorder(in_query1_reorder), .in_query2_reorder(in_query2_reorder),
    .out_query1_ready(out_query1_ready), .out_query2_ready(out_query2_ready),
    .out_query1_value(out_query1_value), .out_query2_value(out_query2_value),
    .out_rob_index(out_rob_index), .out_rob_value(out_rob_value),
    .out_rob_reorder(out_rob_reorder), .out_store_commit(out_store_commit),
    .out_misbranch(out_misbranch), .out_misbranch_pc(out_misbranch_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic st; logic [31:0] val; logic [4:0] exp_idx; } vec_t;
  typedef struct { logic [4:0] idx; logic [31:0] val; logic [3:0] tag; logic st; } exp_t;

  int   checks = 0, errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic mon_rdy;
  logic [3:0] exp_tag = 4'd1;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

  // Commit monitor: every retirement must match the head of the scoreboard.
  always @(posedge clk) begin
    mon_rdy = rdy;
    #1;
    if (mon_rdy && rst && out_rob_reorder != 4'd0) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_commit: got tag %0d expected none", out_rob_reorder);
      end else begin
        mon_e = sb.pop_front();
        check("commit_tag", out_rob_reorder, mon_e.tag);
        check("commit_index", out_rob_index, mon_e.idx);
        check("commit_store", out_store_commit, mon_e.st);
        if (!mon_e.st) check("commit_value", out_rob_value, mon_e.val);
      end
    end
  end

  task automatic dispatch(input logic [4:0] rd, input logic st);
    in_decode_valid = 1'b1; in_decode_rd = rd; in_decode_is_store = st;
    @(negedge clk);
    in_decode_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input logic mb, input logic [31:0] tgt);
    in_cdb_valid = 1'b1; in_cdb_reorder = tag; in_cdb_value = val;
    in_cdb_misbranch = mb; in_cdb_target = tgt;
    @(negedge clk);
    in_cdb_valid = 1'b0; in_cdb_misbranch = 1'b0;
  endtask

  task automatic push(input logic [4:0] idx, input logic [31:0] val, input logic [3:0] tag, input logic st);
    exp_t e;
    e.idx = idx; e.val = val; e.tag = tag; e.st = st;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_free_tag", out_rob_free_tag, 4'd1);
    check("rst_full", out_rob_full, 1'b0);
    check("rst_commit", {out_rob_index, out_rob_value, out_rob_reorder}, '0);
    check("rst_pulses", {out_store_commit, out_misbranch, out_misbranch_pc}, '0);
    @(negedge clk);
    rst = 1'b1;
    exp_tag = 4'd1;
  endtask

  initial begin
    vecs[0] = '{rd: 5'd5,  st: 1'b0, val: 32'h1234,     exp_idx: 5'd5};
    vecs[1] = '{rd: 5'd31, st: 1'b0, val: 32'hFFFF_FFFF, exp_idx: 5'd31};
    vecs[2] = '{rd: 5'd0,  st: 1'b0, val: 32'hA5A5_0000, exp_idx: 5'd0};
    vecs[3] = '{rd: 5'd7,  st: 1'b1, val: 32'h0,        exp_idx: 5'd0};
    vecs[4] = '{rd: 5'd12, st: 1'b0, val: 32'h0,        exp_idx: 5'd12};
    vecs[5] = '{rd: 5'd1,  st: 1'b0, val: 32'hDEAD_BEEF, exp_idx: 5'd1};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      check("vec_free_tag", out_rob_free_tag, exp_tag);
      dispatch(vecs[i].rd, vecs[i].st);
      push(vecs[i].exp_idx, vecs[i].val, exp_tag, vecs[i].st);
      cdb(exp_tag, vecs[i].val, 1'b0, 32'h0);
      exp_tag = nxt(exp_tag);
      drain("vec_drain");
      @(negedge clk);
      check("vec_idle", {out_rob_index, out_rob_reorder, out_store_commit}, '0);
    end

    // Out-of-order completion still retires in order, back to back.
    do_reset();
    dispatch(5'd7, 1'b0);
    dispatch(5'd8, 1'b0);
    push(5'd7, 32'hA, 4'd1, 1'b0);
    push(5'd8, 32'hB, 4'd2, 1'b0);
    cdb(4'd2, 32'hB, 1'b0, 32'h0);
    cdb(4'd1, 32'hA, 1'b0, 32'h0);
    @(negedge clk);
    check("ooo_first", out_rob_reorder, 4'd1);
    @(negedge clk);
    check("ooo_second", out_rob_reorder, 4'd2);
    drain("ooo_drain");

    // Fill to capacity, dispatch while full (also on the commit edge), tag wrap.
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) check("not_full_at_14", out_rob_full, 1'b0);
      dispatch(5'(i), 1'b0);
    end
    check("full_at_15", out_rob_full, 1'b1);
    check("full_free_tag", out_rob_free_tag, 4'd1);
    dispatch(5'd20, 1'b0);
    check("full_ignored", out_rob_free_tag, 4'd1);
    push(5'd1, 32'hF1, 4'd1, 1'b0);
    cdb(4'd1, 32'hF1, 1'b0, 32'h0);
    dispatch(5'd21, 1'b0);
    check("full_after_commit", out_rob_full, 1'b0);
    check("wrap_free_tag", out_rob_free_tag, 4'd1);
    dispatch(5'd22, 1'b0);
    check("wrap_next_tag", out_rob_free_tag, 4'd2);
    drain("full_drain");

    // Mispredicted branch at the head: rd write first, then the flush pulse.
    do_reset();
    dispatch(5'd1, 1'b0);
    dispatch(5'd2, 1'b0);
    dispatch(5'd3, 1'b0);
    push(5'd1, 32'h77, 4'd1, 1'b0);
    cdb(4'd1, 32'h77, 1'b1, 32'h100);
    @(negedge clk);
    check("flush_full", out_rob_full, 1'b1);
    check("flush_no_pulse_yet", out_misbranch, 1'b0);
    @(negedge clk);
    check("flush_pulse", out_misbranch, 1'b1);
    check("flush_pc", out_misbranch_pc, 32'h100);
    check("flush_free_tag", out_rob_free_tag, 4'd1);
    check("flush_not_full", out_rob_full, 1'b0);
    cdb(4'd2, 32'h22, 1'b0, 32'h0);
    check("flush_pulse_end", out_misbranch, 1'b0);
    cdb(4'd3, 32'h33, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    drain("flush_drain");

    // Query with same-cycle CDB bypass, then from storage.
    do_reset();
    dispatch(5'd9, 1'b0);
    dispatch(5'd10, 1'b0);
    in_query1_reorder = 4'd2; in_query2_reorder = 4'd1;
    in_cdb_valid = 1'b1; in_cdb_reorder = 4'd2; in_cdb_value = 32'h55;
    #1;
    check("q_bypass", {out_query1_ready, out_query1_value}, {1'b1, 32'h55});
    check("q_not_ready", out_query2_ready, 1'b0);
    @(negedge clk);
    in_cdb_valid = 1'b0;
    #1;
    check("q_stored", {out_query1_ready, out_query1_value}, {1'b1, 32'h55});
    in_query1_reorder = 4'd0;
    #1;
    check("q_tag0", {out_query1_ready, out_query1_value}, '0);

    // Store retirement gated by rdy, and pulse hold while stalled.
    do_reset();
    dispatch(5'd4, 1'b1);
    cdb(4'd1, 32'h99, 1'b0, 32'h0);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_no_commit", {out_store_commit, out_rob_reorder}, '0);
    push(5'd0, 32'h0, 4'd1, 1'b1);
    rdy = 1'b1;
    @(negedge clk);
    check("store_pulse", out_store_commit, 1'b1);
    rdy = 1'b0;
    @(negedge clk);
    check("store_hold", out_store_commit, 1'b1);
    rdy = 1'b1;
    @(negedge clk);
    check("store_pulse_end", out_store_commit, 1'b0);
    drain("store_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
